// File: rtl/riscv_prefetch_unit_pkg.sv
// Shared types and constants for the RISC-V instruction prefetch unit.
// Holds the fetch FSM state encoding, instruction width and PC step.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

endpackage

// File: rtl/riscv_prefetch_unit_if.sv
// Bus bundle of the prefetch unit: instruction-memory port, decoded
// instruction stream towards the consumer, and the redirect input.
// master = prefetch unit side, slave = memory/consumer side.
interface riscv_prefetch_unit_if #(
  parameter int XLEN = 32
);
  import riscv_fetch_pkg::*;

  logic               mem_req;
  logic [XLEN-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;
  logic               out_ready;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_ack, mem_rdata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_ack, mem_rdata, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/riscv_prefetch_unit_fifo.sv
// prefetch_fifo: synchronous FIFO with occupancy count and flush.
// Flush wins over push/pop. Storage is cleared on reset so the head
// reads as zero until the first push.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s   = push_i & ~flush_i;
  assign do_pop_s    = pop_i & ~flush_i & (count_q != '0);
  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Entry storage: written at the tail on push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/riscv_prefetch_unit.sv
// riscv_prefetch_unit: sequential instruction prefetcher with redirect.
// A 3-state FSM (IDLE/REQ/DROP) issues word fetches only when the buffer
// is guaranteed to have room, so the buffer can never overflow. A redirect
// flushes the buffer; an in-flight fetch is then drained in DROP.
// Optional build macro RISCV_PREFETCH_PERF_EN adds fetch/stall counters.
module riscv_prefetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic                    CLK,
  input  logic                    RST,
  riscv_prefetch_unit_if.master   bus
`ifdef RISCV_PREFETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  localparam logic [1:0] S_IDLE = FS_IDLE;
  localparam logic [1:0] S_REQ  = FS_REQ;
  localparam logic [1:0] S_DROP = FS_DROP;

  logic [1:0]                state_q, state_d;
  logic [XLEN-1:0]           fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]           mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]           redirect_pc_s;
  logic [CW-1:0]             count_s;
  logic [CW-1:0]             occ_after_pop_s;
  logic [CW-1:0]             occ_after_push_s;
  logic                      out_valid_s;
  logic                      pop_s;
  logic                      push_s;
  logic [XLEN+INSTR_W-1:0]   head_s;

  // Redirect outranks both push and pop.
  assign out_valid_s      = (count_s != '0);
  assign pop_s            = out_valid_s & bus.out_ready & ~bus.redirect_valid;
  assign push_s           = (state_q == S_REQ) & bus.mem_ack & ~bus.redirect_valid;
  assign occ_after_pop_s  = count_s - CW'(pop_s);
  assign occ_after_push_s = occ_after_pop_s + CW'(push_s);
  assign redirect_pc_s    = bus.redirect_pc & ~XLEN'(2'b11);

  prefetch_fifo #(
    .WIDTH (XLEN + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (bus.redirect_valid),
    .push_i      (push_s),
    .push_data_i ({fetch_pc_q, bus.mem_rdata}),
    .pop_i       (pop_s),
    .head_data_o (head_s),
    .count_o     (count_s)
  );

  // Next-state logic for the fetch FSM and the fetch PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_pc_s;
        end else if (occ_after_pop_s < DEPTH_C) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_pc_s;
          state_d    = bus.mem_ack ? S_IDLE : S_DROP;
        end else if (bus.mem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = (occ_after_push_s < DEPTH_C) ? S_REQ : S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = redirect_pc_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        state_d = bus.mem_ack ? S_IDLE : S_DROP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The address is frozen while a transaction is outstanding, else it tracks the fetch PC.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if ((state_q != S_IDLE) && !bus.mem_ack) begin
      mem_addr_d = mem_addr_q;
    end else begin
      mem_addr_d = fetch_pc_d;
    end
  end

  // FSM, fetch PC and request address registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.mem_req   = (state_q != S_IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = head_s[XLEN+INSTR_W-1 -: XLEN];
  assign bus.out_instr = head_s[INSTR_W-1:0];

`ifdef RISCV_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Accepted-fetch and consumer-starved cycle counters, wrapping at 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'(push_s);
      perf_stall_q <= perf_stall_q + 32'(bus.out_ready & ~out_valid_s);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_riscv_prefetch_unit.sv
// Directed self-checking bench for riscv_prefetch_unit.
// Inputs change and outputs are checked on the falling clock edge.
// The memory model returns (address + 0x1000_0000) as the instruction word.
module tb_riscv_prefetch_unit;

  localparam logic [31:0] TAG = 32'h1000_0000;

  logic CLK = 1'b0;
  logic RST;
  logic poison;
  int   errors = 0;
  int   checks = 0;

  riscv_prefetch_unit_if #(.XLEN(32)) bus ();

`ifdef RISCV_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  riscv_prefetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef RISCV_PREFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  assign bus.mem_rdata = poison ? 32'hDEAD_BEEF : (bus.mem_addr + TAG);

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ack, logic ready, logic rv, logic [31:0] rpc,
                              logic req, logic [31:0] addr, logic valid, logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.ready = ready; v.rv = rv; v.rpc = rpc;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then wait for the falling edge after the next rising edge.
  task automatic apply(logic rst, logic ack, logic ready, logic rv, logic [31:0] rpc);
    RST                = rst;
    bus.mem_ack        = ack;
    bus.out_ready      = ready;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge CLK);
  endtask

  task automatic expect_out(string name, logic req, logic [31:0] addr, logic valid,
                            logic [31:0] pc, logic chk_data, logic [31:0] instr);
    chk({name, ".mem_req"},   32'(bus.mem_req),   32'(req));
    chk({name, ".mem_addr"},  bus.mem_addr,       addr);
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(valid));
    if (chk_data) begin
      chk({name, ".out_pc"},    bus.out_pc,    pc);
      chk({name, ".out_instr"}, bus.out_instr, instr);
    end
  endtask

  task automatic hs(string name, logic ack, logic ready, logic rv, logic [31:0] rpc,
                    logic req, logic [31:0] addr, logic valid, logic [31:0] pc);
    apply(1'b0, ack, ready, rv, rpc);
    expect_out(name, req, addr, valid, pc, valid, pc + TAG);
  endtask

  initial begin
    poison             = 1'b0;
    RST                = 1'b1;
    bus.mem_ack        = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    //                rst   ack   rdy   rv    rpc    req   addr          vld   pc
    // reset state
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0));
    // streaming, one instruction per cycle
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_000C, 1'b1, 32'h8));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b1, 32'hC));
    // reset mid-fetch, then fill with consumer stalled
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_000C, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0010, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0010, 1'b1, 32'h0));
    // drain in order and resume fetching
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0014, 1'b1, 32'h8));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0018, 1'b1, 32'hC));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_001C, 1'b1, 32'h10));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].ack, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
      expect_out($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                 vecs[i].exp_valid, vecs[i].exp_pc,
                 vecs[i].exp_valid | vecs[i].rst,
                 vecs[i].rst ? 32'h0 : (vecs[i].exp_pc + TAG));
    end

    // Redirect while a fetch is outstanding: drain it in DROP, discard the stale word.
    hs("drop0", 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_001C, 1'b0, 32'h0);
    hs("drop1", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b0, 32'h0);
    hs("drop2", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b0, 32'h0);
    poison = 1'b1;
    hs("drop3", 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0100, 1'b0, 32'h0);
    poison = 1'b0;
    hs("drop4", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0);
    hs("drop5", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);

    // Redirect coinciding with mem_ack and a pop; low address bits ignored.
    hs("rdack0", 1'b1, 1'b1, 1'b1, 32'h0000_0202, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
    hs("rdack1", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b0, 32'h0);
    hs("rdack2", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);

    // Fetch PC wraps around the top of the address space.
    hs("wrap0", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    hs("wrap1", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    hs("wrap2", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
    hs("wrap3", 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

`ifdef RISCV_PREFETCH_PERF_EN
    // 3 starved cycles, then 5 accepted fetches.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("perf_fetch_reset", perf_fetch_cnt, 32'd0);
    chk("perf_stall_reset", perf_stall_cnt, 32'd0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
